// File: rtl/parking_pkg.sv
// Shared types and constants for the coin/start input path into parking_meter.
package parking_pkg;

   localparam int CREDIT_W_DEFAULT        = 8;
   localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;
   localparam int N_COIN_TABLE            = 3;

   typedef logic [CREDIT_W_DEFAULT-1:0] credit_t;

   // Seconds credited per coin switch: SW0 = 5 s, SW1 = 10 s, SW2 = 20 s
   localparam credit_t COIN_VALUE [N_COIN_TABLE] = '{8'd5, 8'd10, 8'd20};

endpackage

// File: rtl/coin_input_conditioner_debouncer.sv
// One raw switch: 2-FF synchroniser, stability counter, debounced level and
// a registered one-cycle pulse on each accepted rise.
module switch_debouncer
   import parking_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic clk,
   input  logic reset,
   input  logic raw_i,
   output logic stable_o,
   output logic rise_o
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

   logic             sync1_q, sync2_q;
   logic             stable_q, stable_d;
   logic             rise_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Any cycle where the synced input agrees with the stable level restarts the count
   always_comb begin
      stable_d = stable_q;
      cnt_d    = '0;
      if (sync2_q != stable_q) begin
         if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            stable_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         stable_q <= 1'b0;
         cnt_q    <= '0;
         rise_q   <= 1'b0;
      end else begin
         sync1_q  <= raw_i;
         sync2_q  <= sync1_q;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
         rise_q   <= stable_d & ~stable_q;
      end
   end

   assign stable_o = stable_q;
   assign rise_o   = rise_q;

endmodule

// File: rtl/coin_input_conditioner.sv
// Debounces the coin and start switches and offers coin credits one at a time
// on a valid/ready channel; also provides a clean start level and start pulse.
module coin_input_conditioner
   import parking_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
   parameter int N_COINS         = 3,
   parameter int CREDIT_W        = 8,
   localparam int ID_W           = (N_COINS > 1) ? $clog2(N_COINS) : 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [N_COINS-1:0]  sw_coin,
   input  logic                sw_start,
   output logic                coin_valid,
   input  logic                coin_ready,
   output logic [CREDIT_W-1:0] coin_value,
   output logic [ID_W-1:0]     coin_id,
   output logic                start_level,
   output logic                start_pulse,
   output logic                overrun
);

   if (N_COINS < 1 || N_COINS > N_COIN_TABLE) begin : g_bad_ncoins
      $error("N_COINS must be between 1 and %0d", N_COIN_TABLE);
   end
   for (genvar g = 0; g < N_COINS && g < N_COIN_TABLE; g++) begin : g_width_chk
      if (int'(COIN_VALUE[g]) >= (1 << CREDIT_W)) begin : g_bad_value
         $error("COIN_VALUE[%0d] does not fit in CREDIT_W bits", g);
      end
   end

   logic [N_COINS-1:0] coin_rise;
   logic               start_rise;

   for (genvar g = 0; g < N_COINS; g++) begin : g_coin_db
      logic coin_stable_unused;
      switch_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
         .clk      (clk),
         .reset    (reset),
         .raw_i    (sw_coin[g]),
         .stable_o (coin_stable_unused),
         .rise_o   (coin_rise[g])
      );
   end

   switch_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start_db (
      .clk      (clk),
      .reset    (reset),
      .raw_i    (sw_start),
      .stable_o (start_level),
      .rise_o   (start_rise)
   );

   logic [N_COINS-1:0]  pend_q, pend_d;
   logic [N_COINS-1:0]  clr_mask, held_mask, kept;
   logic                valid_q, valid_d;
   logic [CREDIT_W-1:0] value_q, value_d;
   logic [ID_W-1:0]     id_q, id_d;
   logic                overrun_q, overrun_d;
   logic                start_pulse_q;
   logic                load, found;

   // A coin whose credit is still pending or still being offered is busy:
   // a fresh rise on it is dropped and flagged as an overrun.
   always_comb begin
      load      = !valid_q || coin_ready;
      found     = 1'b0;
      clr_mask  = '0;
      held_mask = '0;
      valid_d   = valid_q;
      value_d   = value_q;
      id_d      = id_q;
      for (int i = 0; i < N_COINS; i++) begin
         if (valid_q && !coin_ready && id_q == ID_W'(i)) begin
            held_mask[i] = 1'b1;
         end
      end
      if (load) begin
         valid_d = 1'b0;
         for (int i = 0; i < N_COINS; i++) begin
            if (!found && pend_q[i]) begin
               found       = 1'b1;
               clr_mask[i] = 1'b1;
               valid_d     = 1'b1;
               id_d        = ID_W'(i);
               value_d     = CREDIT_W'(COIN_VALUE[i]);
            end
         end
      end
      kept      = pend_q & ~clr_mask;
      pend_d    = kept | (coin_rise & ~held_mask);
      overrun_d = overrun_q | (|(coin_rise & (kept | held_mask)));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_q        <= '0;
         valid_q       <= 1'b0;
         value_q       <= '0;
         id_q          <= '0;
         overrun_q     <= 1'b0;
         start_pulse_q <= 1'b0;
      end else begin
         pend_q        <= pend_d;
         valid_q       <= valid_d;
         value_q       <= value_d;
         id_q          <= id_d;
         overrun_q     <= overrun_d;
         start_pulse_q <= start_rise;
      end
   end

   assign coin_valid  = valid_q;
   assign coin_value  = value_q;
   assign coin_id     = id_q;
   assign overrun     = overrun_q;
   assign start_pulse = start_pulse_q;

endmodule

// File: tb/tb_coin_input_conditioner.sv
// Scenario bench for coin_input_conditioner with a short debounce window,
// compared cycle by cycle against a rule-level reference model.
module tb_coin_input_conditioner;

   localparam int DB  = 4;
   localparam int NC  = 3;
   localparam int CW  = 8;
   localparam int IDW = 2;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [NC-1:0] sw_coin = '0;
   logic          sw_start = 1'b0;
   logic          coin_ready = 1'b1;
   logic          coin_valid;
   logic [CW-1:0] coin_value;
   logic [IDW-1:0] coin_id;
   logic          start_level, start_pulse, overrun;

   int checks = 0;
   int failures = 0;

   coin_input_conditioner #(.DEBOUNCE_CYCLES(DB), .N_COINS(NC), .CREDIT_W(CW)) dut (
      .clk         (clk),
      .reset       (reset),
      .sw_coin     (sw_coin),
      .sw_start    (sw_start),
      .coin_valid  (coin_valid),
      .coin_ready  (coin_ready),
      .coin_value  (coin_value),
      .coin_id     (coin_id),
      .start_level (start_level),
      .start_pulse (start_pulse),
      .overrun     (overrun)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // Channel 0..2 = coins, 3 = start. A switch's clean level flips once the
   // last DB synchronised samples all disagree with it.
   logic [7:0] VAL [NC] = '{8'd5, 8'd10, 8'd20};
   bit  m_s1 [4], m_s2 [4], m_stab [4], m_rise [4];
   bit  m_win [4][DB];
   bit  m_pend [NC];
   bit  m_v, m_ovr, m_sp;
   int  m_id;
   logic [7:0] m_val;
   int  held, pick;
   bit  acc, allmis, s;
   logic [3:0] raw;

   assign raw = {sw_start, sw_coin};

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int c = 0; c < 4; c++) begin
            m_s1[c] = 0; m_s2[c] = 0; m_stab[c] = 0; m_rise[c] = 0;
            for (int k = 0; k < DB; k++) m_win[c][k] = 0;
         end
         for (int i = 0; i < NC; i++) m_pend[i] = 0;
         m_v = 0; m_ovr = 0; m_sp = 0; m_id = 0; m_val = 0;
      end else begin
         held = (m_v && !coin_ready) ? m_id : -1;
         acc  = !m_v || coin_ready;
         if (acc) begin
            pick = -1;
            for (int i = 0; i < NC; i++) if (pick < 0 && m_pend[i]) pick = i;
            if (pick >= 0) begin
               m_v = 1; m_id = pick; m_val = VAL[pick]; m_pend[pick] = 0;
            end else begin
               m_v = 0;
            end
         end
         for (int i = 0; i < NC; i++) begin
            if (m_rise[i]) begin
               if (m_pend[i] || held == i) m_ovr = 1;
               else m_pend[i] = 1;
            end
         end
         m_sp = m_rise[3];
         for (int c = 0; c < 4; c++) begin
            s = m_s2[c];
            for (int k = DB - 1; k > 0; k--) m_win[c][k] = m_win[c][k-1];
            m_win[c][0] = s;
            allmis = 1;
            for (int k = 0; k < DB; k++) if (m_win[c][k] == m_stab[c]) allmis = 0;
            m_rise[c] = 0;
            if (allmis) begin
               m_stab[c] = s;
               m_rise[c] = s;
            end
            m_s2[c] = m_s1[c];
            m_s1[c] = raw[c];
         end
      end
   end

   logic [14:0] dut_vec, mdl_vec;
   assign dut_vec = {coin_valid, coin_value, coin_id, start_level, start_pulse, overrun};
   assign mdl_vec = {m_v, m_val, IDW'(m_id), m_stab[3], m_sp, m_ovr};

   // ---------------- stimulus plumbing ----------------
   logic [9:0] obs [$];   // accepted credits, {id, value}

   task automatic tick();
      bit x;
      logic [9:0] e;
      x = coin_valid && coin_ready;
      e = {coin_id, coin_value};
      @(posedge clk);
      if (x && !reset) obs.push_back(e);
      #1;
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      sw_coin = '0; sw_start = 1'b0; coin_ready = 1'b1;
      tick(); tick();
      reset = 1'b0;
      obs.delete();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b1;
      sw_coin = '1; sw_start = 1'b1;
      tick(); tick(); tick();
      checks++;
      if (dut_vec !== 15'd0) begin
         failures++;
         $display("FAIL reset_outputs got=%h want=0", dut_vec);
      end
      apply_reset();
      checks++;
      if (dut_vec !== 15'd0) begin
         failures++;
         $display("FAIL after_reset_outputs got=%h want=0", dut_vec);
      end
   endtask

   task automatic test_single_coin();
      apply_reset();
      sw_coin[0] = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         tick();
         checks++;
         if (coin_valid !== (k == 8)) begin
            failures++;
            $display("FAIL single_valid edge=%0d got=%b want=%b", k, coin_valid, (k == 8));
         end
         checks++;
         if (dut_vec !== mdl_vec) begin
            failures++;
            $display("FAIL single_model edge=%0d got=%h want=%h", k, dut_vec, mdl_vec);
         end
      end
      checks++;
      if (obs.size() != 1 || obs[0] !== {2'd0, 8'd5}) begin
         failures++;
         $display("FAIL single_credits got_n=%0d first=%h want_n=1 first=005", obs.size(),
                  (obs.size() > 0) ? obs[0] : 10'h3ff);
      end
   endtask

   task automatic test_bounce();
      apply_reset();
      for (int k = 1; k <= 30; k++) begin
         if (k <= 12) sw_coin[1] = (((k - 1) / 2) % 2 == 0);
         else sw_coin[1] = 1'b1;
         tick();
         checks++;
         if (coin_valid !== (k == 20)) begin
            failures++;
            $display("FAIL bounce_valid edge=%0d got=%b want=%b", k, coin_valid, (k == 20));
         end
         checks++;
         if (dut_vec !== mdl_vec) begin
            failures++;
            $display("FAIL bounce_model edge=%0d got=%h want=%h", k, dut_vec, mdl_vec);
         end
      end
      checks++;
      if (obs.size() != 1 || obs[0] !== {2'd1, 8'd10}) begin
         failures++;
         $display("FAIL bounce_credits got_n=%0d want_n=1 value 10 id 1", obs.size());
      end
   endtask

   task automatic test_simultaneous();
      logic [9:0] want;
      apply_reset();
      sw_coin = 3'b101;
      for (int k = 1; k <= 14; k++) begin
         tick();
         want = (k == 8) ? {2'd0, 8'd5} : (k == 9) ? {2'd2, 8'd20} : 10'd0;
         checks++;
         if (coin_valid !== (k == 8 || k == 9) ||
             (coin_valid && {coin_id, coin_value} !== want)) begin
            failures++;
            $display("FAIL simul_out edge=%0d got v=%b %h want v=%b %h", k, coin_valid,
                     {coin_id, coin_value}, (k == 8 || k == 9), want);
         end
         checks++;
         if (dut_vec !== mdl_vec) begin
            failures++;
            $display("FAIL simul_model edge=%0d got=%h want=%h", k, dut_vec, mdl_vec);
         end
      end
      checks++;
      if (obs.size() != 2) begin
         failures++;
         $display("FAIL simul_credits got_n=%0d want_n=2", obs.size());
      end
   endtask

   task automatic test_backpressure();
      apply_reset();
      coin_ready = 1'b0;
      for (int k = 1; k <= 50; k++) begin
         if (k == 1)  sw_coin[0] = 1'b1;
         if (k == 11) sw_coin[1] = 1'b1;
         if (k == 21) sw_coin[0] = 1'b0;
         if (k == 31) sw_coin[0] = 1'b1;
         tick();
         if (k >= 8) begin
            checks++;
            if (coin_valid !== 1'b1 || coin_value !== 8'd5 || coin_id !== 2'd0) begin
               failures++;
               $display("FAIL hold_out edge=%0d got v=%b val=%0d id=%0d want v=1 val=5 id=0",
                        k, coin_valid, coin_value, coin_id);
            end
         end
         checks++;
         if (dut_vec !== mdl_vec) begin
            failures++;
            $display("FAIL hold_model edge=%0d got=%h want=%h", k, dut_vec, mdl_vec);
         end
      end
      checks++;
      if (overrun !== 1'b1) begin
         failures++;
         $display("FAIL hold_overrun got=%b want=1", overrun);
      end
      coin_ready = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         tick();
         checks++;
         if (dut_vec !== mdl_vec) begin
            failures++;
            $display("FAIL release_model cyc=%0d got=%h want=%h", k, dut_vec, mdl_vec);
         end
      end
      checks++;
      if (obs.size() != 2 || obs[0] !== {2'd0, 8'd5} || obs[1] !== {2'd1, 8'd10}) begin
         failures++;
         $display("FAIL release_credits got_n=%0d want 5 then 10", obs.size());
      end
   endtask

   task automatic test_reset_mid_debounce();
      apply_reset();
      sw_coin[2] = 1'b1;
      tick(); tick();
      reset = 1'b1;
      #1;
      checks++;
      if (dut_vec !== 15'd0) begin
         failures++;
         $display("FAIL midreset_outputs got=%h want=0", dut_vec);
      end
      sw_coin[2] = 1'b0;
      tick();
      reset = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         tick();
         checks++;
         if (coin_valid !== 1'b0 || dut_vec !== mdl_vec) begin
            failures++;
            $display("FAIL midreset_idle cyc=%0d got=%h want=%h", k, dut_vec, mdl_vec);
         end
      end
      checks++;
      if (obs.size() != 0) begin
         failures++;
         $display("FAIL midreset_credits got_n=%0d want_n=0", obs.size());
      end
   endtask

   task automatic test_start();
      int pulses;
      pulses = 0;
      apply_reset();
      sw_start = 1'b1;
      for (int k = 1; k <= 45; k++) begin
         if (k == 31) sw_start = 1'b0;
         tick();
         pulses += int'(start_pulse);
         checks++;
         if (start_level !== (k >= 6 && k < 36) || start_pulse !== (k == 7)) begin
            failures++;
            $display("FAIL start edge=%0d got lvl=%b pls=%b want lvl=%b pls=%b", k,
                     start_level, start_pulse, (k >= 6 && k < 36), (k == 7));
         end
         checks++;
         if (dut_vec !== mdl_vec) begin
            failures++;
            $display("FAIL start_model edge=%0d got=%h want=%h", k, dut_vec, mdl_vec);
         end
      end
      checks++;
      if (pulses != 1) begin
         failures++;
         $display("FAIL start_pulse_count got=%0d want=1", pulses);
      end
   endtask

   task automatic test_random();
      apply_reset();
      for (int k = 1; k <= 2000; k++) begin
         for (int i = 0; i < NC; i++) if ($urandom_range(29) == 0) sw_coin[i] = ~sw_coin[i];
         if ($urandom_range(29) == 0) sw_start = ~sw_start;
         coin_ready = ($urandom_range(3) != 0);
         reset = ($urandom_range(399) == 0);
         tick();
         checks++;
         if (dut_vec !== mdl_vec) begin
            failures++;
            $display("FAIL random_model cyc=%0d got=%h want=%h", k, dut_vec, mdl_vec);
         end
      end
      reset = 1'b0;
   endtask

   initial begin
      #1;
      test_reset();
      test_single_coin();
      test_bounce();
      test_simultaneous();
      test_backpressure();
      test_reset_mid_debounce();
      test_start();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
